// File: rtl/rs_pkg.sv
// Shared constants, parity matrix and status payload for the (40,32) code.
package rs_pkg;

  localparam int unsigned RS_N     = 40;
  localparam int unsigned RS_K     = 32;
  localparam int unsigned RS_R     = 8;
  localparam int unsigned RS_IDX_W = 6;
  localparam int unsigned RS_RW    = 3;  // index width into an R-bit vector
  localparam int unsigned RS_KW    = 5;  // index width into a K-bit vector

  // Decoder FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYND   = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Parity rows P_j; parity bit cw[7-j] covers the data bits selected by P_j.
  // Every data column carries bit 7 plus exactly one of bits 6/5, so all
  // columns have weight >= 2 and are pairwise distinct.
  localparam logic [RS_K-1:0] RS_PARITY_ROWS [RS_R] = '{
    32'hFFFF_FFFF,
    32'hFFFF_0000,
    32'h0000_FFFF,
    32'hFFFF_0000,
    32'hFF00_FF00,
    32'hF0F0_F0F0,
    32'h3333_3333,
    32'h5555_5555
  };

  // Result flags presented alongside the corrected data
  typedef struct packed {
    logic [RS_R-1:0]     syndrome;
    logic                corrected;
    logic                uncorrectable;
    logic [RS_IDX_W-1:0] err_pos;
  } rs_status_t;

  // Parity bits for a data word; shared by encoder and decoder syndrome path.
  function automatic logic [RS_R-1:0] rs_parity(input logic [RS_K-1:0] data);
    logic [RS_R-1:0] p;
    p = '0;
    for (int unsigned j = 0; j < RS_R; j++) begin
      p[RS_RW'(RS_R - 1 - j)] = ^(data & RS_PARITY_ROWS[RS_RW'(j)]);
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_hcol.sv
// Parity-check matrix column lookup: H column for codeword bit index idx.
module rs_hcol
  import rs_pkg::*;
(
  input  logic [RS_IDX_W-1:0] idx,
  output logic [RS_R-1:0]     col_c
);

  logic [RS_KW-1:0] didx;

  assign didx = RS_KW'(idx - RS_IDX_W'(RS_R));

  // Parity positions are one-hot; data positions take column didx of P
  always_comb begin
    col_c = '0;
    if (idx < RS_IDX_W'(RS_R)) begin
      col_c[idx[RS_RW-1:0]] = 1'b1;
    end else begin
      for (int unsigned j = 0; j < RS_R; j++) begin
        col_c[RS_RW'(RS_R - 1 - j)] = RS_PARITY_ROWS[RS_RW'(j)][didx];
      end
    end
  end

endmodule

// File: rtl/rs_decoder_seq.sv
// Sequential single-error-correcting decoder for the (40,32) code:
// syndrome in one cycle, then a serial search over the 40 H columns.
module rs_decoder_seq
  import rs_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RS_N-1:0]     in_cw,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [RS_K-1:0]     out_data,
  output logic [RS_R-1:0]     out_syndrome,
  output logic                out_corrected,
  output logic                out_uncorrectable,
  output logic [RS_IDX_W-1:0] out_err_pos,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam logic [RS_IDX_W-1:0] LAST_IDX = RS_IDX_W'(RS_N - 1);

  logic [1:0]          state_q, state_d;
  logic [RS_N-1:0]     cw_q, cw_d;
  logic [RS_IDX_W-1:0] idx_q, idx_d;
  rs_status_t          stat_q, stat_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;

  logic [RS_R-1:0]     synd_c;
  logic [RS_R-1:0]     hcol_c;
  logic [RS_N-1:0]     flip_c;

  rs_hcol u_hcol (
    .idx   (idx_q),
    .col_c (hcol_c)
  );

  assign synd_c = cw_q[RS_R-1:0] ^ rs_parity(cw_q[RS_N-1:RS_R]);

  // One-hot mask for the bit currently under test
  always_comb begin
    flip_c        = '0;
    flip_c[idx_q] = 1'b1;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    idx_d   = idx_q;
    stat_d  = stat_q;
    valid_d = valid_q;
    ready_d = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && ready_q) begin
          cw_d    = in_cw;
          ready_d = 1'b0;
          state_d = ST_SYND;
        end
      end
      ST_SYND: begin
        stat_d.syndrome      = synd_c;
        stat_d.corrected     = 1'b0;
        stat_d.uncorrectable = 1'b0;
        stat_d.err_pos       = '0;
        idx_d                = '0;
        state_d              = (synd_c == '0) ? ST_DONE : ST_SEARCH;
      end
      ST_SEARCH: begin
        if (hcol_c == stat_q.syndrome) begin
          cw_d             = cw_q ^ flip_c;
          stat_d.err_pos   = idx_q;
          stat_d.corrected = 1'b1;
          state_d          = ST_DONE;
        end else if (idx_q == LAST_IDX) begin
          stat_d.uncorrectable = 1'b1;
          state_d              = ST_DONE;
        end else begin
          idx_d = idx_q + RS_IDX_W'(1);
        end
      end
      ST_DONE: begin
        // First DONE cycle raises out_valid; a handshake only counts once it is up
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d              = 1'b0;
          stat_d.corrected     = 1'b0;
          stat_d.uncorrectable = 1'b0;
          stat_d.err_pos       = '0;
          ready_d              = 1'b1;
          state_d              = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cw_q    <= '0;
      idx_q   <= '0;
      stat_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      idx_q   <= idx_d;
      stat_q  <= stat_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready          = ready_q;
  assign out_data          = cw_q[RS_N-1:RS_R];
  assign out_syndrome      = stat_q.syndrome;
  assign out_corrected     = stat_q.corrected;
  assign out_uncorrectable = stat_q.uncorrectable;
  assign out_err_pos       = stat_q.err_pos;
  assign out_valid         = valid_q;

endmodule

// File: tb/tb_rs_decoder_seq.sv
// Directed bench for rs_decoder_seq with an independent column/encoder model.
module tb_rs_decoder_seq;

  logic        clk;
  logic        rst_n;
  logic [39:0] in_cw;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [7:0]  out_syndrome;
  logic        out_corrected;
  logic        out_uncorrectable;
  logic [5:0]  out_err_pos;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  logic [31:0] d;
  logic [39:0] enc;
  logic [39:0] cwv;
  logic [7:0]  sv;
  int          lat;
  int          stray;
  int          pa [3] = '{8, 9, 0};
  int          pb [3] = '{11, 30, 1};

  rs_decoder_seq dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_cw             (in_cw),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_syndrome      (out_syndrome),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .out_err_pos       (out_err_pos),
    .out_valid         (out_valid),
    .out_ready         (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // H column model: parity bits one-hot, data bit i -> {1, i[4], ~i[4], i^3}
  function automatic logic [7:0] col(input int k);
    logic [4:0] i;
    if (k < 8) return 8'h01 << k;
    i = 5'(k - 8);
    return {1'b1, i[4], ~i[4], i ^ 5'd3};
  endfunction

  function automatic logic [39:0] encode(input logic [31:0] data);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (data[i]) p ^= col(8 + i);
    return {data, p};
  endfunction

  task automatic wait_valid(output int l);
    l = 0;
    while (out_valid !== 1'b1 && l < 64) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  task automatic run_case(input string tag, input logic [39:0] cw, input logic [31:0] e_data,
                          input logic [7:0] e_synd, input logic e_corr, input logic e_unc,
                          input logic [5:0] e_pos, input int e_lat);
    int l;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_cw    = cw;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(l);
    chk({tag, ".lat"}, 64'(l), 64'(e_lat));
    chk({tag, ".data"}, 64'(out_data), 64'(e_data));
    chk({tag, ".synd"}, 64'(out_syndrome), 64'(e_synd));
    chk({tag, ".corr"}, 64'(out_corrected), 64'(e_corr));
    chk({tag, ".unc"}, 64'(out_uncorrectable), 64'(e_unc));
    chk({tag, ".pos"}, 64'(out_err_pos), 64'(e_pos));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".retire_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".retire_ready"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_cw     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.data", 64'(out_data), 64'd0);
    chk("rst.synd", 64'(out_syndrome), 64'd0);
    chk("rst.flags", 64'({out_corrected, out_uncorrectable}), 64'd0);
    chk("rst.pos", 64'(out_err_pos), 64'd0);
    rst_n = 1'b1;

    // Hand-computed vectors
    run_case("clean0", 40'h0, 32'h0, 8'h00, 1'b0, 1'b0, 6'd0, 2);
    run_case("par0", 40'h01, 32'h0, 8'h01, 1'b1, 1'b0, 6'd0, 3);
    run_case("dat8", 40'h100, 32'h0, 8'hA3, 1'b1, 1'b0, 6'd8, 11);

    // Encoded random word, then a single flip at every position
    d   = $urandom;
    enc = encode(d);
    run_case("enc_clean", enc, d, 8'h00, 1'b0, 1'b0, 6'd0, 2);
    for (int i = 0; i < 40; i++) begin
      cwv = enc ^ (40'd1 << i);
      run_case($sformatf("flip%0d", i), cwv, d, col(i), 1'b1, 1'b0, 6'(i), 3 + i);
    end

    // Double flips whose syndrome matches no column
    for (int p = 0; p < 3; p++) begin
      cwv = enc ^ (40'd1 << pa[p]) ^ (40'd1 << pb[p]);
      sv  = col(pa[p]) ^ col(pb[p]);
      run_case($sformatf("dbl%0d_%0d", pa[p], pb[p]), cwv, cwv[39:8], sv, 1'b0, 1'b1, 6'd0, 42);
    end

    // Backpressure: hold result, ignore a pending word, then retire and accept it
    d   = 32'h1234_5678;
    enc = encode(d);
    @(negedge clk);
    in_cw    = enc;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_cw = 40'h100;
    wait_valid(lat);
    chk("bp.lat", 64'(lat), 64'd2);
    chk("bp.data", 64'(out_data), 64'(d));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.hold_valid", 64'(out_valid), 64'd1);
      chk("bp.hold_data", 64'(out_data), 64'(d));
      chk("bp.hold_synd", 64'(out_syndrome), 64'd0);
      chk("bp.hold_corr", 64'(out_corrected), 64'd0);
      chk("bp.hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.drop_valid", 64'(out_valid), 64'd0);
    chk("bp.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.accepted", 64'(in_ready), 64'd0);
    wait_valid(lat);
    chk("bp2.lat", 64'(lat), 64'd11);
    chk("bp2.pos", 64'(out_err_pos), 64'd8);
    chk("bp2.synd", 64'(out_syndrome), 64'hA3);
    chk("bp2.data", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of the column search
    in_cw    = 40'h100;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid.pre_synd", 64'(out_syndrome), 64'hA3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid.valid", 64'(out_valid), 64'd0);
    chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid.data", 64'(out_data), 64'd0);
    chk("rst_mid.synd", 64'(out_syndrome), 64'd0);
    chk("rst_mid.flags", 64'({out_corrected, out_uncorrectable}), 64'd0);
    chk("rst_mid.pos", 64'(out_err_pos), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    chk("rst_mid.stray_valid", 64'(stray), 64'd0);
    chk("rst_mid.in_ready_after", 64'(in_ready), 64'd1);
    d   = 32'hCAFE_F00D;
    enc = encode(d);
    run_case("post_rst", enc, d, 8'h00, 1'b0, 1'b0, 6'd0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_decoder_seq.md
Name: rs_decoder_seq

Overview:
- Sequential single-bit-error-correcting decoder for the team's systematic (40,32) binary block code.
- It is the receive-side counterpart of the combinational encoder.
- Accepts one 40-bit codeword per valid/ready transaction and computes the 8-bit syndrome.
- Serially searches the parity-check columns for a single-bit error, then presents corrected data plus status flags on a valid/ready output.

Parameters:
N, 40, codeword width in bits
K, 32, data width in bits
R, 8, parity width (N-K)
IDX_W, 6, width of bit-index counter (ceil log2 N)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_cw  input  N  received codeword; cw[39:8] data (cw[8+i] = data bit i), cw[7:0] parity
in_valid  input  1  in_cw valid
in_ready  output  1  decoder can accept a codeword
out_data  output  K  corrected data bits
out_syndrome  output  R  syndrome of received word
out_corrected  output  1  single-bit error found and fixed
out_uncorrectable  output  1  nonzero syndrome matched no column
out_err_pos  output  IDX_W  codeword bit index corrected (0..39), 0 if none
out_valid  output  1  out_* valid
out_ready  input  1  downstream accepts result

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; all out_* = 0; in_ready=1.
  - Internal cw/syndrome/index registers = 0.
  - Reset mid-operation discards the word in flight; no output is produced for it.
- Parity matrix: rows P_j (j=0..7, K bits each), identical to the encoder's parity rows.
  - Encoder rule: cw[7-j] = XOR(data & P_j).
- Syndrome: s[7-j] = cw[7-j] ^ XOR(cw[39:8] & P_j).
- H column for index k:
  - k<8: one-hot bit k.
  - k>=8: bit (7-j) = P_j[k-8].
- FSM states: IDLE, SYND, SEARCH, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_cw -> SYND. in_ready=0 in all other states; no back-to-back overlap.
- SYND (1 cycle): compute and register syndrome; idx<=0.
  - Syndrome zero -> DONE, corrected=0, uncorrectable=0.
  - Syndrome nonzero -> SEARCH.
- SEARCH (one column per cycle, idx ascending 0..39; first match wins):
  - Match -> flip cw[idx], err_pos<=idx, corrected<=1 -> DONE.
  - idx==39 with no match -> uncorrectable<=1, cw unchanged, err_pos=0 -> DONE.
  - Otherwise idx++.
- DONE: out_valid=1; outputs stable while out_ready=0.
  - On out_ready: out_valid<=0, flags cleared -> IDLE.
- Latency (accept at edge T; out_valid high after edge):
  - clean word: T+2
  - error at index i: T+3+i
  - uncorrectable: T+42
- out_data = registered cw[39:8] after correction. Parity-bit errors (idx<8) flag corrected but leave out_data unchanged.
- in_cw is ignored outside IDLE. out_ready is ignored outside DONE.
- Simultaneous out_ready and new in_valid: the result is retired first; the new word is accepted in the following IDLE cycle.

Decomposition:
- Shared package rs_pkg:
  - RS_N, RS_K, RS_R
  - RS_PARITY_ROWS (R x K constant array)
  - state enum
  - The encoder is refactored to read RS_PARITY_ROWS too.
- Sub-module rs_hcol: combinational; idx in, R-bit H column out, built from RS_PARITY_ROWS.
- Syndrome XOR tree, FSM, counter and output registers live in the top.

Test Plan:
- Clean word: in_cw=40'h0, out_ready=1 -> out_valid at T+2; out_data=0, syndrome=0, corrected=0, uncorrectable=0.
- Parity-bit error: in_cw=40'h01 -> syndrome=8'h01, corrected=1, err_pos=0, out_data=0, latency T+3.
- Data-bit error: in_cw=40'h100 (cw[8] flipped) -> syndrome=8'hA3, corrected=1, err_pos=8, out_data=0, latency T+11.
- Random data, encoded by the golden model, single flip at every index 0..39 -> out_data equals original data, err_pos equals flipped index, latency T+3+i. Double flips whose golden syndrome matches no column -> uncorrectable=1, out_data=received cw[39:8], latency T+42.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> all outputs stable, in_ready=0, new in_valid ignored. Raise out_ready -> out_valid drops next edge, in_ready=1.
- Reset mid-SEARCH (in_cw=40'h100, assert rst_n low at T+5) -> all outputs 0 immediately, in_ready=1 after release, no stray out_valid; the next clean word decodes normally.
